// File: rtl/regfile_xfer_seq.sv
// Bulk register transfer sequencer for CHIP-8 Fx55 (store V0..Vx) and Fx65 (load V0..Vx).
// Owns the register-file port and a memory request port for the duration of an op.
module regfile_xfer_seq #(
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [3:0]    last_reg,
  input  logic [IW-1:0] i_base,
  input  logic          incr_i,
  output logic [3:0]    reg_addr,
  input  logic [DW-1:0] reg_rdata,
  output logic          reg_we,
  output logic [DW-1:0] reg_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          i_we,
  output logic [IW-1:0] i_wdata,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] XFER  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          op_q, op_d;
  logic [3:0]    x_q, x_d;
  logic [IW-1:0] base_q, base_d;
  logic          incr_q, incr_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [IW-1:0] addr_sum;

  // Address is formed at full I width, then truncated so it wraps mod 2^AW.
  assign addr_sum = base_q + IW'(idx_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    x_d       = x_q;
    base_d    = base_q;
    incr_d    = incr_q;
    hold_d    = hold_q;
    reg_addr  = '0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_we      = 1'b0;
    i_wdata   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          x_d     = last_reg;
          base_d  = i_base;
          incr_d  = incr_i;
          idx_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = ~op_q;
        mem_addr  = addr_sum[AW-1:0];
        reg_addr  = idx_q;
        mem_wdata = reg_rdata;
        if (mem_ack) begin
          if (op_q) begin
            hold_d  = mem_rdata;
            state_d = WRITE;
          end else if (idx_q == x_q) begin
            state_d = FIN;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      WRITE: begin
        busy      = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = idx_q;
        reg_wdata = hold_q;
        if (idx_q == x_q) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = XFER;
        end
      end
      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        i_we    = incr_q;
        i_wdata = base_q + IW'(x_q) + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= 1'b0;
      x_q     <= '0;
      base_q  <= '0;
      incr_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      x_q     <= x_d;
      base_q  <= base_d;
      incr_q  <= incr_d;
      hold_q  <= hold_d;
    end
  end

endmodule
